// File: rtl/raccoon_mover_if.sv
// raccoon_mover_if
//   Bundles the raccoon mover's button/sync inputs and its sprite-position
//   outputs so the mover and whatever drives it share one connection.
//
//   btnUp/btnDown/btnLeft/btnRight : raw, asynchronous, active-high buttons
//   vgaVs                          : vertical sync from the VGA block (active-low)
//   raccoonX/raccoonY              : sprite position in pixels
//   busy                           : high while a slide is in progress
//
//   master : the side that drives buttons/vgaVs and reads the position
//   slave  : the raccoon mover itself
interface raccoon_mover_if;
  logic       btnUp;
  logic       btnDown;
  logic       btnLeft;
  logic       btnRight;
  logic       vgaVs;
  logic [9:0] raccoonX;
  logic [9:0] raccoonY;
  logic       busy;

  modport master (
    output btnUp, btnDown, btnLeft, btnRight, vgaVs,
    input  raccoonX, raccoonY, busy
  );

  modport slave (
    input  btnUp, btnDown, btnLeft, btnRight, vgaVs,
    output raccoonX, raccoonY, busy
  );
endinterface

// File: rtl/raccoon_mover.sv
// raccoon_mover
//   Turns four raw push-buttons into one-cell moves of the raccoon sprite.
//   Each button is synchronised and debounced; a debounced press starts a
//   slide of CELL_PX pixels, advanced STEP_PX pixels on every frame tick
//   (rising edge of vgaVs) so the sprite never moves mid-frame.
//
//   clk  : pixel clock (same as the VGA block)
//   rstN : asynchronous active-low reset
//   bus  : raccoon_mover_if.slave -- buttons and vgaVs in, raccoonX/raccoonY/busy out
module raccoon_mover #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CELL_PX         = 32,
  parameter int unsigned STEP_PX         = 4,
  parameter int unsigned MAX_X           = 608,
  parameter int unsigned MAX_Y           = 448,
  parameter int unsigned START_X         = 0,
  parameter int unsigned START_Y         = 0
) (
  input  logic           clk,
  input  logic           rstN,
  raccoon_mover_if.slave bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] CELL_W    = 11'(CELL_PX);
  localparam logic [9:0]  STEP_W    = 10'(STEP_PX);
  localparam logic [10:0] MAX_X_W   = 11'(MAX_X);
  localparam logic [10:0] MAX_Y_W   = 11'(MAX_Y);
  localparam logic [9:0]  START_X_W = 10'(START_X);
  localparam logic [9:0]  START_Y_W = 10'(START_Y);

  typedef enum logic {
    IDLE,
    SLIDE
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // Button order in all 4-bit vectors: [3]=Up [2]=Down [1]=Left [0]=Right,
  // so a higher index is also a higher priority.
  logic [3:0] btn_raw;
  assign btn_raw = {bus.btnUp, bus.btnDown, bus.btnLeft, bus.btnRight};

  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            db_q, db_d;
  logic [3:0]            db_dly_q, db_dly_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  vs_prev_q, vs_prev_d;

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] target_q, target_d;
  logic       busy_q, busy_d;

  logic [3:0] press;
  logic       tick;

  // Synchroniser and debounce: the counter only runs while the synchronised
  // level disagrees with the debounced state, so any bounce back restarts it.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_dly_d  = db_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    vs_prev_d = bus.vgaVs;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A press is the debounced 0->1 edge only, so a held button fires once.
  assign press = db_q & ~db_dly_q;

  // End of vertical sync: vgaVs was low last cycle and is high now.
  assign tick = ~vs_prev_q & bus.vgaVs;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // Move FSM. Candidate targets are computed in 11 bits so that stepping
  // below zero shows up as a huge value and fails the same range check as
  // stepping past the right/bottom edge.
  always_comb begin
    logic [10:0] cand;
    logic        cand_ok;
    dir_e        sel_dir;
    logic [9:0]  step;

    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    target_d = target_q;
    busy_d   = busy_q;
    cand     = '0;
    cand_ok  = 1'b0;
    sel_dir  = DIR_UP;
    step     = '0;

    case (state_q)
      IDLE: begin
        if (|press) begin
          if (press[3]) begin
            sel_dir = DIR_UP;
            cand    = {1'b0, y_q} - CELL_W;
            cand_ok = (cand <= MAX_Y_W);
          end else if (press[2]) begin
            sel_dir = DIR_DOWN;
            cand    = {1'b0, y_q} + CELL_W;
            cand_ok = (cand <= MAX_Y_W);
          end else if (press[1]) begin
            sel_dir = DIR_LEFT;
            cand    = {1'b0, x_q} - CELL_W;
            cand_ok = (cand <= MAX_X_W);
          end else begin
            sel_dir = DIR_RIGHT;
            cand    = {1'b0, x_q} + CELL_W;
            cand_ok = (cand <= MAX_X_W);
          end
          if (cand_ok) begin
            dir_d    = sel_dir;
            target_d = cand[9:0];
            busy_d   = 1'b1;
            state_d  = SLIDE;
          end
        end
      end

      SLIDE: begin
        if (tick) begin
          case (dir_q)
            DIR_UP: begin
              step = y_q - STEP_W;
              y_d  = step;
            end
            DIR_DOWN: begin
              step = y_q + STEP_W;
              y_d  = step;
            end
            DIR_LEFT: begin
              step = x_q - STEP_W;
              x_d  = step;
            end
            default: begin
              step = x_q + STEP_W;
              x_d  = step;
            end
          endcase
          if (step == target_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      x_q      <= START_X_W;
      y_q      <= START_Y_W;
      target_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      target_q <= target_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.raccoonX = x_q;
  assign bus.raccoonY = y_q;
  assign bus.busy     = busy_q;

endmodule
